rot_stream_stage: RTL and testbench

ROT_STREAM_STAGE -- requirements
Module: rot_stream_stage

---
 rtl/rot_pkg.sv | 37 +++
 rtl/barrel_shifter.sv | 31 +++
 rtl/rot_stream_stage.sv | 102 ++++++++++
 tb/tb_rot_stream_stage.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// -----------------------------------------------------------------------------
// rot_pkg
// Shared widths, direction encoding and helpers for the rotate stream stage.
//   DATA_W        : byte width being rotated
//   AMT_W         : width of the rotate distance
//   rot_dir_e     : ROT_RIGHT = 0, ROT_LEFT = 1
//   rot_req_t     : request as held in S1 (data + effective right-rotate amount)
//   eff_right_amt : maps (amount, direction) onto an equivalent right-rotate amount
// -----------------------------------------------------------------------------
package rot_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned AMT_W  = 3;

   typedef enum logic {
      ROT_RIGHT = 1'b0,
      ROT_LEFT  = 1'b1
   } rot_dir_e;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [AMT_W-1:0]  amt;
   } rot_req_t;

   // Rotate-left by n equals rotate-right by (DATA_W - n) mod DATA_W. DATA_W is a
   // power of two equal to 2**AMT_W, so the modulo is just AMT_W-bit wraparound.
   function automatic logic [AMT_W-1:0] eff_right_amt(input logic [AMT_W-1:0] amt,
                                                      input rot_dir_e        dir);
      logic [AMT_W-1:0] eff;
      eff = amt;
      if (dir == ROT_LEFT) begin
         eff = AMT_W'(0) - amt;
      end
      return eff;
   endfunction

endpackage

// File: rtl/barrel_shifter.sv
// -----------------------------------------------------------------------------
// barrel_shifter
// Purely combinational right-rotate of a DATA_W-bit word, built as AMT_W
// logarithmic stages (rotate by 1, 2, 4, ...).
//   i_data       : word to rotate
//   i_shift_amt  : right-rotate distance
//   o_shift_data : rotated word
// -----------------------------------------------------------------------------
module barrel_shifter
   import rot_pkg::*;
(
   input  logic [DATA_W-1:0] i_data,
   input  logic [AMT_W-1:0]  i_shift_amt,
   output logic [DATA_W-1:0] o_shift_data
);

   // stage[k] is the input after applying amount bits [k-1:0].
   logic [AMT_W:0][DATA_W-1:0] stage;

   assign stage[0] = i_data;

   for (genvar k = 0; k < AMT_W; k++) begin : g_stage
      localparam int unsigned Sh = 1 << k;
      logic [DATA_W-1:0] rotated;
      assign rotated        = {stage[k][Sh-1:0], stage[k][DATA_W-1:Sh]};
      assign stage[k+1]     = i_shift_amt[k] ? rotated : stage[k];
   end

   assign o_shift_data = stage[AMT_W];

endmodule

// File: rtl/rot_stream_stage.sv
// -----------------------------------------------------------------------------
// rot_stream_stage
// Two-stage elastic valid/ready pipeline that rotates a byte.
//   S1 holds the captured request: the byte unchanged plus the direction folded
//   into an equivalent right-rotate amount. S2 holds the rotated result.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   i_valid      : upstream request valid
//   o_ready      : request accepted this cycle when high together with i_valid
//   i_data       : byte to rotate
//   i_shift_amt  : rotate distance 0..7
//   i_dir        : 0 = rotate right, 1 = rotate left
//   o_valid      : o_shift_data holds a result
//   i_ready      : downstream takes the result this cycle
//   o_shift_data : rotated byte
//   o_busy       : either stage holds a request
// -----------------------------------------------------------------------------
module rot_stream_stage
   import rot_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_data,
   input  logic [AMT_W-1:0]  i_shift_amt,
   input  logic              i_dir,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_shift_data,
   output logic              o_busy
);

   // Stage state
   logic              s1_valid_q, s1_valid_d;
   rot_req_t          s1_q, s1_d;
   logic              s2_valid_q, s2_valid_d;
   logic [DATA_W-1:0] s2_data_q, s2_data_d;

   // Handshake decode
   logic              s2_adv;
   logic              s1_adv;
   logic              in_xfer;
   logic [DATA_W-1:0] rot_data;

   // S2 may load whenever it is empty or its content leaves this cycle.
   assign s2_adv  = ~s2_valid_q | i_ready;
   assign s1_adv  = s1_valid_q & s2_adv;
   // Held low during reset so nothing is accepted while state is being cleared.
   assign o_ready = ~reset & (~s1_valid_q | s2_adv);
   assign in_xfer = i_valid & o_ready;

   barrel_shifter u_barrel_shifter (
      .i_data       (s1_q.data),
      .i_shift_amt  (s1_q.amt),
      .o_shift_data (rot_data)
   );

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_d       = s1_q;
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;

      // S1: a new capture wins over draining, which keeps S1 full when a request
      // enters while the previous one moves on to S2.
      if (in_xfer) begin
         s1_valid_d = 1'b1;
         s1_d.data  = i_data;
         s1_d.amt   = eff_right_amt(i_shift_amt, rot_dir_e'(i_dir));
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end

      // S2: data only loads on a real hand-over so a stalled result never moves.
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_data_d = rot_data;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_q       <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_q       <= s1_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
      end
   end

   assign o_valid      = s2_valid_q;
   assign o_shift_data = s2_data_q;
   assign o_busy       = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_rot_stream_stage.sv
// -----------------------------------------------------------------------------
// tb_rot_stream_stage
// Directed vector table, hand-written stall/reset sequences and a random
// valid/ready run scored against a queue of expected results.
// -----------------------------------------------------------------------------
module tb_rot_stream_stage;

   logic       clk;
   logic       reset;
   logic       i_valid;
   logic       o_ready;
   logic [7:0] i_data;
   logic [2:0] i_shift_amt;
   logic       i_dir;
   logic       o_valid;
   logic       i_ready;
   logic [7:0] o_shift_data;
   logic       o_busy;

   int checks   = 0;
   int failures = 0;

   rot_stream_stage dut (
      .clk          (clk),
      .reset        (reset),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_data       (i_data),
      .i_shift_amt  (i_shift_amt),
      .i_dir        (i_dir),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_shift_data (o_shift_data),
      .o_busy       (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic [2:0] amt;
      logic       dir;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Bit-at-a-time rotate, independent of the log-stage structure in the DUT.
   function automatic logic [7:0] rot_ref(input logic [7:0] d, input logic [2:0] a,
                                          input logic dir);
      logic [7:0] r;
      r = d;
      for (int i = 0; i < int'(a); i++) begin
         r = dir ? {r[6:0], r[7]} : {r[0], r[7:1]};
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] a,
                        input logic dir);
      i_valid     = v;
      i_data      = d;
      i_shift_amt = a;
      i_dir       = dir;
   endtask

   logic [7:0] stream_exp[8];
   logic [7:0] exp_q[$];
   logic [7:0] held;
   logic       hold_chk;
   int         acc;
   int         recv;
   int         cyc;

   initial begin
      vecs[0] = '{8'hA5, 3'd1, 1'b0, 8'hD2};
      vecs[1] = '{8'hA5, 3'd1, 1'b1, 8'h4B};
      vecs[2] = '{8'h81, 3'd3, 1'b1, 8'h0C};
      vecs[3] = '{8'h3C, 3'd0, 1'b0, 8'h3C};
      vecs[4] = '{8'h3C, 3'd0, 1'b1, 8'h3C};
      vecs[5] = '{8'h81, 3'd7, 1'b1, 8'hC0};
      vecs[6] = '{8'h01, 3'd4, 1'b0, 8'h10};
      vecs[7] = '{8'hF0, 3'd4, 1'b1, 8'h0F};
      vecs[8] = '{8'h96, 3'd2, 1'b0, 8'hA5};
      vecs[9] = '{8'h96, 3'd5, 1'b1, 8'hD2};
      stream_exp = '{8'h81, 8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03};

      // ---------------- reset state ----------------
      reset   = 1'b1;
      i_ready = 1'b1;
      drive(1'b0, 8'h00, 3'd0, 1'b0);
      #2;
      check("rst_o_valid", o_valid, 0);
      check("rst_o_busy", o_busy, 0);
      check("rst_o_ready", o_ready, 0);
      check("rst_o_data", o_shift_data, 0);
      tick();
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_o_ready", o_ready, 1);
      check("post_rst_o_valid", o_valid, 0);

      // ---------------- directed vectors, latency 2 ----------------
      for (int v = 0; v < 10; v++) begin
         tick();
         drive(1'b1, vecs[v].data, vecs[v].amt, vecs[v].dir);
         @(negedge clk);
         check($sformatf("vec%0d_accept", v), o_ready, 1);
         tick();
         i_valid = 1'b0;
         @(negedge clk);
         check($sformatf("vec%0d_lat1_valid", v), o_valid, 0);
         tick();
         @(negedge clk);
         check($sformatf("vec%0d_lat2_valid", v), o_valid, 1);
         check($sformatf("vec%0d_data", v), o_shift_data, vecs[v].exp);
      end
      tick();

      // ---------------- back-to-back stream ----------------
      for (int c = 0; c < 10; c++) begin
         if (c < 8) drive(1'b1, 8'h81, 3'(c), 1'b0);
         else       drive(1'b0, 8'h00, 3'd0, 1'b0);
         @(negedge clk);
         if (c < 8) check($sformatf("stream%0d_ready", c), o_ready, 1);
         if (c >= 2) begin
            check($sformatf("stream%0d_valid", c - 2), o_valid, 1);
            check($sformatf("stream%0d_data", c - 2), o_shift_data, stream_exp[c-2]);
         end
         tick();
      end
      @(negedge clk);
      check("stream_no_dup", o_valid, 0);

      // ---------------- backpressure ----------------
      tick();
      i_ready = 1'b0;
      drive(1'b1, 8'hA5, 3'd1, 1'b0);          // R0 -> D2
      @(negedge clk);
      check("bp_r0_ready", o_ready, 1);
      tick();
      drive(1'b1, 8'h81, 3'd3, 1'b1);          // R1 -> 0C
      @(negedge clk);
      check("bp_r1_ready", o_ready, 1);
      for (int c = 0; c < 3; c++) begin
         tick();
         drive(1'b1, 8'(8'h11 * (c + 1)), 3'(c + 2), c[0]);  // ignored
         @(negedge clk);
         check($sformatf("bp_stall%0d_ready", c), o_ready, 0);
         check($sformatf("bp_stall%0d_valid", c), o_valid, 1);
         check($sformatf("bp_stall%0d_data", c), o_shift_data, 8'hD2);
      end
      tick();
      i_ready = 1'b1;
      drive(1'b1, 8'h3C, 3'd2, 1'b0);          // R2 -> 0F
      @(negedge clk);
      check("bp_r2_ready", o_ready, 1);
      check("bp_out0", o_shift_data, 8'hD2);
      tick();
      i_valid = 1'b0;
      @(negedge clk);
      check("bp_out1_valid", o_valid, 1);
      check("bp_out1", o_shift_data, 8'h0C);
      tick();
      @(negedge clk);
      check("bp_out2_valid", o_valid, 1);
      check("bp_out2", o_shift_data, 8'h0F);
      tick();
      @(negedge clk);
      check("bp_drained_valid", o_valid, 0);
      check("bp_drained_busy", o_busy, 0);

      // ---------------- reset with both stages full ----------------
      tick();
      i_ready = 1'b0;
      drive(1'b1, 8'h55, 3'd1, 1'b0);
      @(negedge clk);
      check("mrst_a_ready", o_ready, 1);
      tick();
      drive(1'b1, 8'h33, 3'd2, 1'b1);
      @(negedge clk);
      check("mrst_b_ready", o_ready, 1);
      tick();
      i_valid = 1'b0;
      @(negedge clk);
      check("mrst_full_valid", o_valid, 1);
      check("mrst_full_ready", o_ready, 0);
      #1;
      reset = 1'b1;
      #1;
      check("mrst_o_valid", o_valid, 0);
      check("mrst_o_busy", o_busy, 0);
      check("mrst_o_ready", o_ready, 0);
      check("mrst_o_data", o_shift_data, 0);
      tick();
      check("mrst_hold_data", o_shift_data, 0);
      @(negedge clk);
      reset   = 1'b0;
      i_ready = 1'b1;
      #1;
      check("mrst_release_ready", o_ready, 1);
      for (int c = 0; c < 4; c++) begin
         tick();
         @(negedge clk);
         check($sformatf("mrst_stale%0d_valid", c), o_valid, 0);
         check($sformatf("mrst_stale%0d_busy", c), o_busy, 0);
      end

      // ---------------- random valid/ready against a queue ----------------
      acc      = 0;
      recv     = 0;
      cyc      = 0;
      hold_chk = 1'b0;
      held     = 8'h00;
      while ((acc < 10000 || exp_q.size() != 0) && cyc < 60000) begin
         tick();
         cyc++;
         drive((acc < 10000) && ($urandom_range(0, 9) < 7), 8'($urandom),
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         i_ready = ($urandom_range(0, 9) < 7);
         @(negedge clk);
         if (hold_chk) begin
            check("rand_stall_valid", o_valid, 1);
            check("rand_stall_data", o_shift_data, held);
         end
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
               check("rand_unexpected_output", 1, 0);
            end else begin
               check("rand_data", o_shift_data, exp_q.pop_front());
            end
            recv++;
         end
         if (i_valid && o_ready) begin
            exp_q.push_back(rot_ref(i_data, i_shift_amt, i_dir));
            acc++;
         end
         hold_chk = o_valid && !i_ready;
         held     = o_shift_data;
      end
      if (cyc >= 60000) check("rand_timeout", 1, 0);
      check("rand_recv_count", recv, 10000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
